// File: rtl/dual_port_ram_copier.sv
// -----------------------------------------------------------------------------
// dual_port_ram_copier
//   Block-copy initiator for a dual-port RAM. Words are read through port 1 and
//   written back through port 2 at one word per clock. The copy follows memmove
//   semantics: overlapping ranges with the destination above the source are
//   copied top-down so that no source word is overwritten before it is read.
//
//   Optional feature macro: DPRC_FILL_EN
//     When defined, adds ports fill/fill_data. A request with fill=1 writes
//     fill_data to dst..dst+len-1 and performs no reads.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request, sampled only while idle
//   src_addr, dst_addr    first source / destination word
//   len                   word count, 0..DEPTH (0 is rejected)
//   busy                  transfer in progress
//   done                  one-cycle completion pulse (also on reject)
//   err                   one-cycle pulse together with done on reject
//   addr_p1, wr_p1,
//   data_p1, out_p1       RAM port 1 (read only, wr_p1/data_p1 tied to 0)
//   addr_p2, data_p2,
//   wr_p2                 RAM port 2 (write only)
//   fill, fill_data       (DPRC_FILL_EN only) fill request and fill value
// -----------------------------------------------------------------------------
module dual_port_ram_copier #(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   len,
`ifdef DPRC_FILL_EN
   input  logic          fill,
   input  logic [DW-1:0] fill_data,
`endif
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] addr_p1,
   output logic          wr_p1,
   output logic [DW-1:0] data_p1,
   input  logic [DW-1:0] out_p1,
   output logic [AW-1:0] addr_p2,
   output logic [DW-1:0] data_p2,
   output logic          wr_p2
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

   state_t        state_reg, state_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;
   logic          wr_p2_reg, wr_p2_next;
   logic [AW-1:0] addr_p1_reg, addr_p1_next;
   logic [AW-1:0] addr_p2_reg, addr_p2_next;
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW:0]   cnt_reg, cnt_next;
   logic [AW:0]   len_reg, len_next;
   logic          desc_reg, desc_next;

   // request decode (sums are AW+1 bits wide so they cannot overflow)
   logic [AW:0] src_end, dst_end, src_last, dst_last;
   logic        req_fill, run_fill, reject, desc_req;

   assign src_end  = {1'b0, src_addr} + len;
   assign dst_end  = {1'b0, dst_addr} + len;
   assign src_last = src_end - 1'b1;
   assign dst_last = dst_end - 1'b1;
   assign desc_req = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);

`ifdef DPRC_FILL_EN
   logic          fill_reg;
   logic [DW-1:0] fill_data_reg;

   assign req_fill = fill;
   assign run_fill = fill_reg;
   assign data_p2  = fill_reg ? fill_data_reg : out_p1;

   // fill parameters are captured only when a request is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_reg      <= 1'b0;
         fill_data_reg <= '0;
      end else if (state_reg == IDLE && start && !reject) begin
         fill_reg      <= fill;
         fill_data_reg <= fill_data;
      end
   end
`else
   assign req_fill = 1'b0;
   assign run_fill = 1'b0;
   assign data_p2  = out_p1;
`endif

   // a fill ignores the source range entirely
   assign reject = (len == '0) || (dst_end > DEPTH_W) ||
                   (!req_fill && (src_end > DEPTH_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         wr_p2_reg   <= 1'b0;
         addr_p1_reg <= '0;
         addr_p2_reg <= '0;
         wr_ptr_reg  <= '0;
         cnt_reg     <= '0;
         len_reg     <= '0;
         desc_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         wr_p2_reg   <= wr_p2_next;
         addr_p1_reg <= addr_p1_next;
         addr_p2_reg <= addr_p2_next;
         wr_ptr_reg  <= wr_ptr_next;
         cnt_reg     <= cnt_next;
         len_reg     <= len_next;
         desc_reg    <= desc_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      err_next     = 1'b0;
      wr_p2_next   = 1'b0;
      addr_p1_next = addr_p1_reg;
      addr_p2_next = addr_p2_reg;
      wr_ptr_next  = wr_ptr_reg;
      cnt_next     = cnt_reg;
      len_next     = len_reg;
      desc_next    = desc_reg;

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               if (reject) begin
                  state_next = FINISH;
                  done_next  = 1'b1;
                  err_next   = 1'b1;
               end else begin
                  state_next = RUN;
                  busy_next  = 1'b1;
                  cnt_next   = '0;
                  len_next   = len;
                  if (req_fill) begin
                     // fill writes start immediately: word 0 goes out in cycle 0
                     desc_next    = 1'b0;
                     wr_p2_next   = 1'b1;
                     addr_p2_next = dst_addr;
                     wr_ptr_next  = dst_addr + 1'b1;
                  end else begin
                     desc_next    = desc_req;
                     addr_p1_next = desc_req ? src_last[AW-1:0] : src_addr;
                     wr_ptr_next  = desc_req ? dst_last[AW-1:0] : dst_addr;
                  end
               end
            end
         end

         RUN: begin
            if (run_fill) begin
               if (cnt_reg + 1'b1 == len_reg) begin
                  state_next = FINISH;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  wr_p2_next   = 1'b1;
                  addr_p2_next = wr_ptr_reg;
                  wr_ptr_next  = wr_ptr_reg + 1'b1;
                  cnt_next     = cnt_reg + 1'b1;
               end
            end else if (cnt_reg == len_reg) begin
               // last write is on the bus this cycle
               state_next = FINISH;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               // write word cnt (its read data arrives now), read word cnt+1
               wr_p2_next   = 1'b1;
               addr_p2_next = wr_ptr_reg;
               wr_ptr_next  = desc_reg ? wr_ptr_reg - 1'b1 : wr_ptr_reg + 1'b1;
               // no step past the last word, so the read address never wraps
               if (cnt_reg + 1'b1 < len_reg)
                  addr_p1_next = desc_reg ? addr_p1_reg - 1'b1 : addr_p1_reg + 1'b1;
               cnt_next = cnt_reg + 1'b1;
            end
         end

         FINISH: state_next = IDLE;

         default: state_next = IDLE;
      endcase
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign err     = err_reg;
   assign wr_p2   = wr_p2_reg;
   assign addr_p1 = addr_p1_reg;
   assign addr_p2 = addr_p2_reg;
   assign wr_p1   = 1'b0;
   assign data_p1 = '0;

endmodule

// File: tb/tb_dual_port_ram_copier.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_copier
//   Bench for dual_port_ram_copier with a behavioural dual-port RAM (registered
//   read). Expected writes are queued when a request is driven and popped as the
//   DUT writes; final RAM contents are compared against a memmove reference.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_copier;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [5:0] src_addr, dst_addr;
   logic [6:0] len;
`ifdef DPRC_FILL_EN
   logic       fill;
   logic [7:0] fill_data;
`endif
   logic       busy, done, err;
   logic [5:0] addr_p1, addr_p2;
   logic       wr_p1, wr_p2;
   logic [7:0] data_p1, data_p2, out_p1;

   // preload port into the bench RAM
   logic       pl_we;
   logic [5:0] pl_addr;
   logic [7:0] pl_data;

   logic [7:0] mem  [64];
   logic [7:0] gold [64];

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;
   wr_t exp_q[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_port_ram_copier #(.AW(6), .DW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
`ifdef DPRC_FILL_EN
      .fill     (fill),
      .fill_data(fill_data),
`endif
      .busy     (busy),
      .done     (done),
      .err      (err),
      .addr_p1  (addr_p1),
      .wr_p1    (wr_p1),
      .data_p1  (data_p1),
      .out_p1   (out_p1),
      .addr_p2  (addr_p2),
      .data_p2  (data_p2),
      .wr_p2    (wr_p2)
   );

   // dual-port RAM model: port 1 registered read, port 2 write
   always @(posedge clk) begin
      if (pl_we)
         mem[pl_addr] <= pl_data;
      else if (wr_p2)
         mem[addr_p2] <= data_p2;
      out_p1 <= mem[addr_p1];
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < 64; i++) begin
         logic [7:0] v;
         v = (i == 1) ? 8'd45 : (i == 2) ? 8'd32 : (i == 3) ? 8'd24 : 8'(i * 5 + 100);
         gold[i] = v;
         @(negedge clk);
         pl_we   = 1'b1;
         pl_addr = 6'(i);
         pl_data = v;
      end
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic verify_mem(input string tag);
      int nbad;
      nbad = 0;
      for (int i = 0; i < 64; i++)
         if (mem[i] !== gold[i]) nbad++;
      check_val(tag, nbad, 0);
   endtask

   // restart_cyc: cycle at which start is pulsed again (-1 = never)
   // rst_cyc:     cycle at which rst_n is pulled low (large = never)
   task automatic run_xfer(input int src, input int dst, input int ln, input bit fil,
                           input int fdat, input int restart_cyc, input int rst_cyc);
      bit  rej, desc;
      int  snap[64];
      int  exp_done_cyc, busy_last, ndone, word;
      bit  was_reset;
      wr_t e;

      rej = fil ? (ln == 0 || dst + ln > 64)
                : (ln == 0 || src + ln > 64 || dst + ln > 64);
      desc = !fil && (dst > src) && (dst < src + ln);
      for (int i = 0; i < 64; i++) snap[i] = gold[i];
      if (!rej) begin
         for (int k = 0; k < ln; k++) begin
            word   = desc ? ln - 1 - k : k;
            e.addr = dst + word;
            e.data = fil ? fdat : snap[src + word];
            e.cyc  = fil ? k : k + 1;
            if (e.cyc < rst_cyc) begin
               exp_q.push_back(e);
               gold[e.addr] = 8'(e.data);
            end
         end
      end
      exp_done_cyc = rej ? 0 : (fil ? ln : ln + 1);
      busy_last    = rej ? -1 : (fil ? ln - 1 : ln);
      ndone        = 0;
      was_reset    = 1'b0;

      @(negedge clk);
      src_addr = 6'(src);
      dst_addr = 6'(dst);
      len      = 7'(ln);
`ifdef DPRC_FILL_EN
      fill      = fil;
      fill_data = 8'(fdat);
`endif
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      for (int c = 0; c < ln + 6; c++) begin
         @(negedge clk);
         if (c == rst_cyc) begin
            rst_n = 1'b0;
            #1;
            check_val("rst_wr_p2", wr_p2, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_addr_p2", addr_p2, 0);
            repeat (2) begin
               @(negedge clk);
               check_val("rst_done", done, 0);
            end
            rst_n     = 1'b1;
            was_reset = 1'b1;
            break;
         end
         check_val("busy", busy, (c <= busy_last) ? 1 : 0);
         if (wr_p2) begin
            if (exp_q.size() == 0) begin
               check_val("extra_wr", wr_p2, 0);
            end else begin
               e = exp_q.pop_front();
               check_val("wr_addr", addr_p2, e.addr);
               check_val("wr_data", data_p2, e.data);
               check_val("wr_cyc", c, e.cyc);
            end
         end
         if (done) begin
            ndone++;
            check_val("done_cyc", c, exp_done_cyc);
            check_val("err", err, rej ? 1 : 0);
         end else if (err) begin
            check_val("err_nodone", err, 0);
         end
         if (c == restart_cyc) begin
            src_addr = src_addr + 6'd5;
            start    = 1'b1;
         end else if (c == restart_cyc + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_val("done_cnt", ndone, was_reset ? 0 : 1);
      check_val("q_left", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      $display("xfer src=%0d dst=%0d len=%0d fill=%0d rej=%0d desc=%0d -> dones=%0d",
               src, dst, ln, fil, rej, desc, ndone);
      verify_mem("mem");
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;
      pl_we    = 1'b0;
      pl_addr  = '0;
      pl_data  = '0;
`ifdef DPRC_FILL_EN
      fill      = 1'b0;
      fill_data = '0;
`endif
      repeat (3) @(negedge clk);
      check_val("reset_busy", busy, 0);
      check_val("reset_done", done, 0);
      check_val("reset_err", err, 0);
      check_val("reset_wr_p2", wr_p2, 0);
      check_val("reset_addr_p1", addr_p1, 0);
      check_val("reset_addr_p2", addr_p2, 0);
      check_val("wr_p1", wr_p1, 0);
      check_val("data_p1", data_p1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // plain ascending copy
      preload();
      run_xfer(1, 16, 3, 1'b0, 0, -1, 1000);
      check_val("m16", mem[16], 45);
      check_val("m17", mem[17], 32);
      check_val("m18", mem[18], 24);

      // overlapping copy, destination above source -> descending
      preload();
      run_xfer(1, 2, 3, 1'b0, 0, -1, 1000);
      check_val("m1", mem[1], 45);
      check_val("m2", mem[2], 45);
      check_val("m3", mem[3], 32);
      check_val("m4", mem[4], 24);

      // rejected requests
      run_xfer(5, 9, 0, 1'b0, 0, -1, 1000);
      run_xfer(62, 0, 3, 1'b0, 0, -1, 1000);
      run_xfer(0, 63, 2, 1'b0, 0, -1, 1000);

      // start pulsed again mid-transfer with different source
      run_xfer(8, 30, 4, 1'b0, 0, 2, 1000);

      // reset mid-transfer
      run_xfer(40, 50, 4, 1'b0, 0, -1, 2);

      // overlap with destination below source, upper boundary, full depth
      run_xfer(20, 18, 5, 1'b0, 0, -1, 1000);
      run_xfer(60, 0, 4, 1'b0, 0, -1, 1000);
      run_xfer(0, 0, 64, 1'b0, 0, -1, 1000);
      run_xfer(10, 11, 20, 1'b0, 0, -1, 1000);

`ifdef DPRC_FILL_EN
      preload();
      run_xfer(0, 2, 2, 1'b1, 8'h10, -1, 1000);
      check_val("fill_m2", mem[2], 8'h10);
      check_val("fill_m3", mem[3], 8'h10);
      run_xfer(0, 63, 2, 1'b1, 8'h22, -1, 1000);
      run_xfer(62, 60, 4, 1'b1, 8'h5a, -1, 1000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
